// File: rtl/rs_arb_mux_if.sv
// Read-port request/grant bundle between the execution controllers (master)
// and the register-file source-select arbiter (slave).
interface rs_arb_mux_if #(
  parameter int NCH = 3,
  parameter int AW  = 5
);
  localparam int IDXW = $clog2(NCH);

  logic [NCH-1:0]    req;
  logic [NCH*AW-1:0] addr_in;
  logic [NCH-1:0]    lock;
  logic [NCH-1:0]    gnt;
  logic [AW-1:0]     rs_addr;
  logic              rs_valid;
  logic [IDXW-1:0]   rs_owner;

  modport master (
    output req, addr_in, lock,
    input  gnt, rs_addr, rs_valid, rs_owner
  );

  modport slave (
    input  req, addr_in, lock,
    output gnt, rs_addr, rs_valid, rs_owner
  );
endinterface

// File: rtl/rs_arb_mux.sv
// Round-robin source-register select: one controller wins the regfile read port
// per cycle. Define RS_ARB_LOCK_EN to let a locked owner keep the port.
module rs_arb_mux #(
  parameter int NCH = 3,
  parameter int AW  = 5
) (
  input  logic         clk,
  input  logic         rst,
  rs_arb_mux_if.slave  bus
);
  localparam int IDXW = $clog2(NCH);

  logic [NCH-1:0]  gnt_q,      gnt_d;
  logic [AW-1:0]   rs_addr_q,  rs_addr_d;
  logic            rs_valid_q, rs_valid_d;
  logic [IDXW-1:0] rs_owner_q, rs_owner_d;
  logic [IDXW-1:0] ptr_q,      ptr_d;

  logic [NCH-1:0]  elig;
  logic            found;
  logic [IDXW-1:0] win;
  logic [IDXW-1:0] cand;
  logic [AW-1:0]   sel_addr;
  int              idx;

`ifndef RS_ARB_LOCK_EN
  logic lock_unused;
  assign lock_unused = ^bus.lock;
`endif

  always_comb begin
    // The channel holding the grant this cycle is masked so a held req is not re-granted.
    elig  = bus.req & ~gnt_q;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      cand = IDXW'(idx);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
`ifdef RS_ARB_LOCK_EN
    // A locked owner that still requests keeps the port; ptr already equals it.
    if (rs_valid_q && bus.lock[rs_owner_q] && bus.req[rs_owner_q]) begin
      found = 1'b1;
      win   = rs_owner_q;
    end
`endif

    sel_addr = '0;
    gnt_d    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (win == IDXW'(i)) begin
        sel_addr = bus.addr_in[i*AW +: AW];
        gnt_d[i] = found;
      end
    end

    rs_valid_d = found;
    rs_addr_d  = found ? sel_addr : rs_addr_q;
    rs_owner_d = found ? win      : rs_owner_q;
    ptr_d      = found ? win      : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= '0;
      rs_addr_q  <= '0;
      rs_valid_q <= 1'b0;
      rs_owner_q <= '0;
      ptr_q      <= IDXW'(NCH - 1);
    end else begin
      gnt_q      <= gnt_d;
      rs_addr_q  <= rs_addr_d;
      rs_valid_q <= rs_valid_d;
      rs_owner_q <= rs_owner_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rs_addr  = rs_addr_q;
  assign bus.rs_valid = rs_valid_q;
  assign bus.rs_owner = rs_owner_q;
endmodule
